// File: rtl/dramstore_fifo_bank.sv
// Four independent first-word-fall-through FIFOs that hold DRAM store-row entries.
// Each entry's address is base + row*ROW_BYTES, computed in the write cycle.
package types_pkg;
    localparam int WORD_W       = 32;
    localparam int BITS_PER_ROW = 64;
    localparam int MAT_S_W      = 2;
    localparam int ROW_S_W      = 3;
    localparam int ENTRY_W      = WORD_W + BITS_PER_ROW + MAT_S_W + ROW_S_W;
    localparam int ROW_BYTES    = BITS_PER_ROW / 8;
endpackage

module dramstore_fifo_bank
    import types_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    wen,
    input  logic [MAT_S_W-1:0]      w_mat_s,
    input  logic [ROW_S_W-1:0]      w_row_s,
    input  logic [WORD_W-1:0]       w_base_addr,
    input  logic [BITS_PER_ROW-1:0] w_data,
    output logic                    w_ready,
    input  logic                    dramFIFO0_REN,
    input  logic                    dramFIFO1_REN,
    input  logic                    dramFIFO2_REN,
    input  logic                    dramFIFO3_REN,
    output logic                    dramFIFO0_empty,
    output logic                    dramFIFO1_empty,
    output logic                    dramFIFO2_empty,
    output logic                    dramFIFO3_empty,
    output logic [ENTRY_W-1:0]      dramFIFO0_rdata,
    output logic [ENTRY_W-1:0]      dramFIFO1_rdata,
    output logic [ENTRY_W-1:0]      dramFIFO2_rdata,
    output logic [ENTRY_W-1:0]      dramFIFO3_rdata,
    output logic                    dramFIFO0_full,
    output logic                    dramFIFO1_full,
    output logic                    dramFIFO2_full,
    output logic                    dramFIFO3_full,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [ENTRY_W-1:0] mem_q [4][DEPTH];
    logic [PW-1:0]      wr_ptr_q [4];
    logic [PW-1:0]      wr_ptr_d [4];
    logic [PW-1:0]      rd_ptr_q [4];
    logic [PW-1:0]      rd_ptr_d [4];
    logic [CW-1:0]      cnt_q [4];
    logic [CW-1:0]      cnt_d [4];
    logic               ovf_q, ovf_d;
    logic               udf_q, udf_d;

    logic [3:0]         ren_s, empty_s, full_s, push_s, pop_s;
    logic [1:0]         tgt_s;
    logic [WORD_W-1:0]  addr_s;
    logic [ENTRY_W-1:0] entry_s;
    logic [ENTRY_W-1:0] rdata_s [4];

    assign ren_s   = {dramFIFO3_REN, dramFIFO2_REN, dramFIFO1_REN, dramFIFO0_REN};
    assign tgt_s   = w_mat_s[1:0];
    assign addr_s  = w_base_addr + (WORD_W'(w_row_s) * WORD_W'(ROW_BYTES));
    assign entry_s = {addr_s, w_data, w_mat_s, w_row_s};
    assign w_ready = ~full_s[tgt_s];

    // Per-FIFO status, push/pop qualification and next pointer/count state.
    always_comb begin
        empty_s = 4'b0000;
        full_s  = 4'b0000;
        push_s  = 4'b0000;
        pop_s   = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            empty_s[i]  = (cnt_q[i] == '0);
            full_s[i]   = (cnt_q[i] == DEPTH_C);
            push_s[i]   = wen & (tgt_s == 2'(i)) & ~full_s[i];
            pop_s[i]    = ren_s[i] & ~empty_s[i];
            wr_ptr_d[i] = push_s[i] ? (wr_ptr_q[i] + PW'(1)) : wr_ptr_q[i];
            rd_ptr_d[i] = pop_s[i]  ? (rd_ptr_q[i] + PW'(1)) : rd_ptr_q[i];
            cnt_d[i]    = cnt_q[i] + CW'(push_s[i]) - CW'(pop_s[i]);
            rdata_s[i]  = empty_s[i] ? '0 : mem_q[i][rd_ptr_q[i]];
        end
        ovf_d = ovf_q | (wen & full_s[tgt_s]);
        udf_d = udf_q | (|(ren_s & empty_s));
    end

    // Pointer, count and sticky error flag registers.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    // Entry storage; left unreset because empty masks stale contents.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            if (nRST && push_s[i]) begin
                mem_q[i][wr_ptr_q[i]] <= entry_s;
            end
        end
    end

    assign dramFIFO0_empty = empty_s[0];
    assign dramFIFO1_empty = empty_s[1];
    assign dramFIFO2_empty = empty_s[2];
    assign dramFIFO3_empty = empty_s[3];
    assign dramFIFO0_full  = full_s[0];
    assign dramFIFO1_full  = full_s[1];
    assign dramFIFO2_full  = full_s[2];
    assign dramFIFO3_full  = full_s[3];
    assign dramFIFO0_rdata = rdata_s[0];
    assign dramFIFO1_rdata = rdata_s[1];
    assign dramFIFO2_rdata = rdata_s[2];
    assign dramFIFO3_rdata = rdata_s[3];
    assign overflow        = ovf_q;
    assign underflow       = udf_q;

endmodule

// File: tb/tb_dramstore_fifo_bank.sv
// Scoreboard bench for dramstore_fifo_bank: stimulus pushes expected entries per FIFO,
// a negedge monitor pops and compares whenever a non-empty FIFO is read.
module tb_dramstore_fifo_bank;
    import types_pkg::*;
    localparam int DEPTH = 4;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic                    nRST, wen, w_ready, overflow, underflow;
    logic [1:0]              w_mat_s;
    logic [2:0]              w_row_s;
    logic [31:0]             w_base_addr;
    logic [63:0]             w_data;
    logic [3:0]              ren, empty_w, full_w;
    logic [ENTRY_W-1:0]      rd_w [4];

    dramstore_fifo_bank #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .nRST(nRST), .wen(wen), .w_mat_s(w_mat_s), .w_row_s(w_row_s),
        .w_base_addr(w_base_addr), .w_data(w_data), .w_ready(w_ready),
        .dramFIFO0_REN(ren[0]), .dramFIFO1_REN(ren[1]),
        .dramFIFO2_REN(ren[2]), .dramFIFO3_REN(ren[3]),
        .dramFIFO0_empty(empty_w[0]), .dramFIFO1_empty(empty_w[1]),
        .dramFIFO2_empty(empty_w[2]), .dramFIFO3_empty(empty_w[3]),
        .dramFIFO0_rdata(rd_w[0]), .dramFIFO1_rdata(rd_w[1]),
        .dramFIFO2_rdata(rd_w[2]), .dramFIFO3_rdata(rd_w[3]),
        .dramFIFO0_full(full_w[0]), .dramFIFO1_full(full_w[1]),
        .dramFIFO2_full(full_w[2]), .dramFIFO3_full(full_w[3]),
        .overflow(overflow), .underflow(underflow)
    );

    int                 checks = 0;
    int                 failures = 0;
    logic [ENTRY_W-1:0] expq [4][$];
    int                 msize [4];
    logic               m_ovf, m_udf;
    bit                 mon_en = 1'b0;

    function automatic logic [ENTRY_W-1:0] mk_entry(input logic [1:0] mat, input logic [2:0] row,
                                                    input logic [31:0] base, input logic [63:0] data);
        logic [31:0] a;
        a = base + 32'(row) * 32'd8;
        return {a, data, mat, row};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_state();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("empty%0d", i), 128'(empty_w[i]), 128'(msize[i] == 0));
            chk($sformatf("full%0d", i), 128'(full_w[i]), 128'(msize[i] == DEPTH));
            if (msize[i] == 0) chk($sformatf("rdata_zero%0d", i), 128'(rd_w[i]), 128'd0);
        end
        chk("overflow", 128'(overflow), 128'(m_ovf));
        chk("underflow", 128'(underflow), 128'(m_udf));
    endtask

    // Drive one cycle of inputs (called at posedge+1), advance the model, then check the new state.
    task automatic cycle(input bit rst, input bit w, input logic [1:0] mat, input logic [2:0] row,
                         input logic [31:0] base, input logic [63:0] data, input logic [3:0] r);
        bit exp_ready, do_push, do_pop;
        nRST = ~rst; wen = w; w_mat_s = mat; w_row_s = row;
        w_base_addr = base; w_data = data; ren = r;
        exp_ready = (msize[mat] < DEPTH);
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                msize[i] = 0;
                expq[i].delete();
            end
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (w && msize[mat] == DEPTH) m_ovf = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (r[i] && msize[i] == 0) m_udf = 1'b1;
                do_pop  = r[i] && msize[i] > 0;
                do_push = w && (int'(mat) == i) && msize[i] < DEPTH;
                if (do_push) expq[i].push_back(mk_entry(mat, row, base, data));
                msize[i] = msize[i] + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
            end
        end
        #2;
        chk("w_ready", 128'(w_ready), 128'(exp_ready));
        @(posedge CLK);
        #1;
        check_state();
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 2'd0, 3'd0, 32'd0, 64'd0, 4'b0000);
    endtask

    // Monitor: every accepted read of a non-empty FIFO must present the oldest expected entry.
    always @(negedge CLK) begin
        if (mon_en && nRST === 1'b1) begin
            for (int i = 0; i < 4; i++) begin
                if (ren[i] && empty_w[i] === 1'b0) begin
                    checks++;
                    if (expq[i].size() == 0) begin
                        failures++;
                        $display("FAIL pop_unexpected%0d actual=%0h required=none", i, rd_w[i]);
                    end else begin
                        logic [ENTRY_W-1:0] e;
                        e = expq[i].pop_front();
                        if (rd_w[i] !== e) begin
                            failures++;
                            $display("FAIL pop_data%0d actual=%0h required=%0h", i, rd_w[i], e);
                        end
                    end
                end
            end
        end
    end

    initial begin
        nRST = 1'b0; wen = 1'b0; w_mat_s = 2'd0; w_row_s = 3'd0;
        w_base_addr = 32'd0; w_data = 64'd0; ren = 4'b0000;
        for (int i = 0; i < 4; i++) msize[i] = 0;
        m_ovf = 1'b0; m_udf = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        mon_en = 1'b1;
        check_state();
        chk("reset_w_ready", 128'(w_ready), 128'd1);

        // Single write, address offset base + 3*8.
        cycle(1'b0, 1'b1, 2'd2, 3'd3, 32'h0000_1000, 64'hA5, 4'b0000);
        chk("req033_rdata", 128'(rd_w[2]), 128'({32'h0000_1018, 64'hA5, 2'd2, 3'd3}));
        chk("req033_empty", 128'(empty_w), 128'(4'b1011));
        cycle(1'b0, 1'b0, 2'd0, 3'd0, 32'd0, 64'd0, 4'b0100);

        // Fill FIFO1, overflow on the fifth write, then drain in order.
        for (int k = 0; k < 4; k++)
            cycle(1'b0, 1'b1, 2'd1, 3'(k), 32'h0000_2000, 64'(100 + k), 4'b0000);
        chk("req034_full", 128'(full_w[1]), 128'd1);
        cycle(1'b0, 1'b1, 2'd1, 3'd4, 32'h0000_2000, 64'hDEAD, 4'b0000);
        chk("req034_ovf", 128'(overflow), 128'd1);
        for (int k = 0; k < 4; k++)
            cycle(1'b0, 1'b0, 2'd1, 3'd0, 32'd0, 64'd0, 4'b0010);
        chk("req034_empty", 128'(empty_w[1]), 128'd1);

        // Two entries in FIFO0, then simultaneous push/pop for five cycles.
        cycle(1'b0, 1'b1, 2'd0, 3'd0, 32'h0000_3000, 64'h10, 4'b0000);
        cycle(1'b0, 1'b1, 2'd0, 3'd1, 32'h0000_3000, 64'h11, 4'b0000);
        for (int k = 0; k < 5; k++)
            cycle(1'b0, 1'b1, 2'd0, 3'(k + 2), 32'h0000_3000, 64'(32'h12 + k), 4'b0001);
        chk("req035_full0", 128'(full_w[0]), 128'd0);
        cycle(1'b0, 1'b0, 2'd0, 3'd0, 32'd0, 64'd0, 4'b0001);
        cycle(1'b0, 1'b0, 2'd0, 3'd0, 32'd0, 64'd0, 4'b0001);

        // Address wrap and underflow on an empty FIFO.
        cycle(1'b1, 1'b0, 2'd0, 3'd0, 32'd0, 64'd0, 4'b0000);
        cycle(1'b0, 1'b1, 2'd3, 3'd1, 32'hFFFF_FFF8, 64'h77, 4'b0000);
        chk("req036_addr", 128'(rd_w[3][ENTRY_W-1 -: 32]), 128'd0);
        cycle(1'b0, 1'b0, 2'd0, 3'd0, 32'd0, 64'd0, 4'b1000);
        chk("req036_udf_before", 128'(underflow), 128'd0);
        cycle(1'b0, 1'b0, 2'd0, 3'd0, 32'd0, 64'd0, 4'b1000);
        chk("req036_udf", 128'(underflow), 128'd1);
        chk("req036_empty3", 128'(empty_w[3]), 128'd1);

        // Reset mid-operation with wen and REN asserted.
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b1, 2'd0, 3'(k), 32'h0000_4000, 64'(k), 4'b0000);
            cycle(1'b0, 1'b1, 2'd3, 3'(k), 32'h0000_5000, 64'(k), 4'b0000);
        end
        cycle(1'b1, 1'b1, 2'd0, 3'd5, 32'h0000_6000, 64'hBAD, 4'b1111);
        chk("req037_empty", 128'(empty_w), 128'(4'b1111));
        chk("req037_flags", 128'({overflow, underflow}), 128'd0);
        idle();

        // Randomized traffic.
        for (int k = 0; k < 500; k++) begin
            bit         rst, w;
            logic [31:0] base;
            logic [3:0] r;
            rst  = ($urandom_range(0, 99) == 0);
            w    = ($urandom_range(0, 9) < 6);
            base = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
            for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 9) < 4);
            cycle(rst, w, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), base,
                  {$urandom, $urandom}, r);
        end

        // Drain everything and confirm nothing expected was left behind.
        for (int k = 0; k < DEPTH + 1; k++)
            cycle(1'b0, 1'b0, 2'd0, 3'd0, 32'd0, 64'd0, 4'b1111);
        idle();
        for (int i = 0; i < 4; i++)
            chk($sformatf("drain_q%0d", i), 128'(expq[i].size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
